// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the serial ALU sequencer
//
// Purpose: state encoding, opcode constants and default width used by the
//          serial add/subtract controller and its bus interface.
// Ports:   none (package).

package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int ALU_WIDTH = 8;

endpackage

// File: rtl/alu_serial_add_ctrl_if.sv
// rtl/alu_serial_add_ctrl_if.sv - start/done request bus of the serial add/sub sequencer
//
// Purpose: groups the request (start, op_sub, A, B) and the response
//          (ready, busy, done, Sum, Carry, Overflow[, Zero]) signals.
// Modports: master = requester (drives request, reads response)
//           slave  = sequencer (reads request, drives response)
// Optional: ALU_SERIAL_ZERO_FLAG_EN adds the Zero response flag.

interface alu_serial_add_ctrl_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             Zero;

  modport master (
    output start, op_sub, A, B,
    input  ready, busy, done, Sum, Carry, Overflow, Zero
  );

  modport slave (
    input  start, op_sub, A, B,
    output ready, busy, done, Sum, Carry, Overflow, Zero
  );
`else
  modport master (
    output start, op_sub, A, B,
    input  ready, busy, done, Sum, Carry, Overflow
  );

  modport slave (
    input  start, op_sub, A, B,
    output ready, busy, done, Sum, Carry, Overflow
  );
`endif

endinterface

// File: rtl/alu_serial_add_ctrl_fa_cell.sv
// rtl/alu_serial_add_ctrl_fa_cell.sv - one-bit full adder built from two half adders
//
// Purpose: the single adder cell the serial sequencer reuses every cycle.
// Ports (half_adder):     a, b -> s (sum), c (carry)
// Ports (serial_fa_cell): a, b, cin -> s (sum), cout (carry out)

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  // At most one of the two half adders can generate a carry.
  assign cout = c0 | c1;
endmodule

// File: rtl/alu_serial_add_ctrl.sv
// rtl/alu_serial_add_ctrl.sv - bit-serial add/subtract sequencer with start/done handshake
//
// Purpose: computes A+B or A-B one bit per cycle through a single full-adder
//          cell; done pulses WIDTH+1 cycles after the accepting edge.
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-high reset
//          bus - request/response interface (slave side)
// Optional: ALU_SERIAL_ZERO_FLAG_EN adds the registered Zero flag.

module alu_serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic             c_msb;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             fa_s;
  logic             fa_cout;

  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_cout)
  );

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic zero;
  assign bus.Zero = zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      c        <= 1'b0;
      c_msb    <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sr  <= bus.A;
            b_sr  <= (bus.op_sub == ALU_OP_SUB) ? ~bus.B : bus.B;
            c     <= bus.op_sub;
            cnt   <= '0;
            sum   <= '0;
            state <= ST_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          sum  <= {fa_s, sum[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c    <= fa_cout;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // c is the carry into the MSB on this cycle; needed for Overflow.
            c_msb <= c;
            state <= ST_DONE;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done     <= 1'b1;
          carry    <= c;
          overflow <= c ^ c_msb;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          zero     <= (sum == '0);
`endif
          state    <= ST_IDLE;
          ready    <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.Sum      = sum;
  assign bus.Carry    = carry;
  assign bus.Overflow = overflow;

endmodule

// File: tb/tb_alu_serial_add_ctrl.sv
// tb/tb_alu_serial_add_ctrl.sv - scoreboard bench for the serial add/sub sequencer

module tb_alu_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  alu_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    int   ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (sub) begin
      e.sum   = W'(ua - ub);
      e.carry = (ua >= ub);
      r       = sa - sb;
    end else begin
      e.sum   = W'(ua + ub);
      e.carry = (ua + ub) >= 2**W;
      r       = sa + sb;
    end
    e.ovf  = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      done_cnt = done_cnt + 1;
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(bus.Sum), 32'(e.sum));
        check("carry", 32'(bus.Carry), 32'(e.carry));
        check("overflow", 32'(bus.Overflow), 32'(e.ovf));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        check("zero", 32'(bus.Zero), 32'(e.zero));
`endif
      end
    end
  end

  // Drive a request at a negedge while ready, return at the negedge after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, output int t0);
    int n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(bus.ready), 32'd1);
    bus.start  = 1'b1;
    bus.A      = a;
    bus.B      = b;
    bus.op_sub = sub;
    exp_q.push_back(model(a, b, sub));
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b0;
    check("ready_drop", 32'(bus.ready), 32'd0);
    check("busy_run", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int t0, input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cyc - t0), 32'(W + 1));
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, t2, t3, d0;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.Sum), 32'd0);
    check("rst_carry", 32'(bus.Carry), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);

    // Directed: carry, wrap, signed overflow, borrow.
    start_op(8'h0F, 8'h01, 1'b0, t0); wait_done(t0, "latency_add");
    start_op(8'hFF, 8'h01, 1'b0, t0); wait_done(t0, "latency_wrap");
    start_op(8'h7F, 8'h01, 1'b0, t0); wait_done(t0, "latency_ovf");
    start_op(8'h05, 8'h07, 1'b1, t0); wait_done(t0, "latency_sub");

    // start and operand changes during RUN are ignored.
    d0 = done_cnt;
    start_op(8'h10, 8'h20, 1'b0, t0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h33; bus.op_sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t0, "latency_ignore");
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset mid-RUN discards the operation.
    d0 = done_cnt;
    start_op(8'h55, 8'h0A, 1'b0, t0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_sum", 32'(bus.Sum), 32'd0);
    check("arst_carry", 32'(bus.Carry), 32'd0);
    check("arst_ovf", 32'(bus.Overflow), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    start_op(8'h01, 8'h01, 1'b0, t0); wait_done(t0, "latency_after_rst");

    // Back-to-back with start held high: one done every WIDTH+2 cycles.
    bus.start = 1'b1; bus.A = 8'h80; bus.B = 8'h80; bus.op_sub = 1'b1;
    repeat (3) exp_q.push_back(model(8'h80, 8'h80, 1'b1));
    t1 = 0; t2 = 0; t3 = 0;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      @(negedge clk);
      while (!bus.done && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (k == 0) t1 = cyc;
      if (k == 1) t2 = cyc;
      if (k == 2) t3 = cyc;
    end
    bus.start = 1'b0;
    check("b2b_period1", 32'(t2 - t1), 32'(W + 2));
    check("b2b_period2", 32'(t3 - t2), 32'(W + 2));
    @(negedge clk);

    // Randomized operations.
    for (int k = 0; k < 20; k++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), t0);
      wait_done(t0, "latency_rand");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
